pipe_mem_arbiter: RTL and testbench

Arbiter and sequencer that shares one single-port synchronous memory between the instruction-fetch port and the data-access port of the five-stage pipelined computer. A data access always wins a collision unless instruction fetch has been starved too long. The arbiter drives a stall signal back to the pipeline for each port that is refused. It returns read data, or a write acknowledge, through registered per-port response paths.

---
 rtl/pipe_mem_arbiter.sv | 72 +++++++
 tb/tb_pipe_mem_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one sync single-port memory between fetch and data ports with starvation-bounded priority
module pipe_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_stall,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, IF_RD, DM_RD, DM_WR} trk_t;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  trk_t trk_q, trk_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  always_comb begin
    if_gnt = if_req & (~dm_req | (starve_cnt_q == SMAX));
    dm_gnt = dm_req & ~if_gnt;
    if_stall = if_req & ~if_gnt;
    dm_stall = dm_req & ~dm_gnt;
    mem_en = if_gnt | dm_gnt;
    mem_we = dm_gnt & dm_we;
    mem_addr = if_gnt ? if_addr : dm_gnt ? dm_addr : '0;
    mem_wdata = dm_gnt ? dm_wdata : '0;
    starve_cnt_d = if_stall ? starve_cnt_q + 4'(starve_cnt_q != SMAX) : 4'd0;
    trk_d = if_gnt ? IF_RD : dm_gnt ? (dm_we ? DM_WR : DM_RD) : IDLE;
    if_valid_d = trk_q == IF_RD;
    dm_valid_d = (trk_q == DM_RD) | (trk_q == DM_WR);
    if_rdata_d = (trk_q == IF_RD) ? mem_rdata : if_rdata_q;
    dm_rdata_d = (trk_q == DM_RD) ? mem_rdata : dm_rdata_q;
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      trk_q <= IDLE;
      starve_cnt_q <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      trk_q <= trk_d;
      starve_cnt_q <= starve_cnt_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end
  assign if_valid = if_valid_q;
  assign dm_valid = dm_valid_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb_pipe_mem_arbiter: directed plus random checks of pipe_mem_arbiter against a scoreboard model
module tb_pipe_mem_arbiter;
  localparam int STARVE = 3;
  logic clock = 1'b0, resetn = 1'b0;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic if_gnt, if_stall, if_valid, dm_gnt, dm_stall, dm_valid, mem_en, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata, rd_r;
  logic force_ff = 1'b0;
  logic [31:0] env_mem [256];
  bit env_wr [256];
  logic [31:0] ref_mem [256];
  typedef struct {int due; bit is_if; bit we; logic [31:0] data;} resp_t;
  resp_t q[$];
  int checks = 0, errors = 0, cyc = 0, starve = 0, n_if = 0;
  logic e_if_v = 0, e_dm_v = 0, m_if_g = 0, m_dm_g = 0;
  logic [31:0] e_if_rd = '0, e_dm_rd = '0;
  pipe_mem_arbiter dut (
    .clock(clock), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_stall(dm_stall), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] init_val(input logic [7:0] i);
    return (i == 8'h04) ? 32'hDEADBEEF : ({24'd0, i} * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction
  always @(posedge clock)
    if (mem_en) begin
      if (mem_we) begin
        env_mem[mem_addr[9:2]] <= mem_wdata;
        env_wr[mem_addr[9:2]] <= 1'b1;
      end else rd_r <= env_wr[mem_addr[9:2]] ? env_mem[mem_addr[9:2]] : init_val(mem_addr[9:2]);
    end
  assign mem_rdata = force_ff ? 32'hFFFFFFFF : rd_r;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask
  task automatic cycle();
    logic eig, edg;
    @(negedge clock);
    eig = if_req && (!dm_req || starve == STARVE);
    edg = dm_req && !eig;
    chk("if_gnt", if_gnt, eig);
    chk("dm_gnt", dm_gnt, edg);
    chk("if_stall", if_stall, if_req && !eig);
    chk("dm_stall", dm_stall, dm_req && !edg);
    chk("mem_en", mem_en, eig || edg);
    chk("mem_we", mem_we, edg && dm_we);
    chk("mem_addr", mem_addr, eig ? if_addr : edg ? dm_addr : 32'd0);
    chk("mem_wdata", mem_wdata, edg ? dm_wdata : 32'd0);
    chk("if_valid", if_valid, e_if_v);
    chk("dm_valid", dm_valid, e_dm_v);
    chk("if_rdata", if_rdata, e_if_rd);
    chk("dm_rdata", dm_rdata, e_dm_rd);
    if (!resetn) begin
      q.delete();
      starve = 0;
      {e_if_v, e_dm_v} = '0;
      e_if_rd = '0;
      e_dm_rd = '0;
    end else begin
      starve = (if_req && !eig) ? (starve < STARVE ? starve + 1 : starve) : 0;
      {e_if_v, e_dm_v} = '0;
      while (q.size() > 0 && q[0].due == cyc + 1) begin
        if (q[0].is_if) begin e_if_v = 1; e_if_rd = q[0].data; end
        else begin e_dm_v = 1; if (!q[0].we) e_dm_rd = q[0].data; end
        void'(q.pop_front());
      end
      if (eig) q.push_back('{cyc + 2, 1'b1, 1'b0, ref_mem[if_addr[9:2]]});
      if (edg) q.push_back('{cyc + 2, 1'b0, dm_we, ref_mem[dm_addr[9:2]]});
    end
    if (edg && dm_we) ref_mem[dm_addr[9:2]] = dm_wdata;
    m_if_g = eig;
    m_dm_g = edg;
    @(posedge clock);
    #1;
    cyc++;
  endtask
  task automatic drv(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                     input logic [31:0] da, input logic [31:0] dwd);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = dwe; dm_addr = da; dm_wdata = dwd;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    @(posedge clock);
    #1;
    force_ff = 1'b1;
    drv(1, 32'h40, 1, 1, 32'h80, 32'hCAFE0001);
    cycle();
    drv(1, 32'h44, 0, 0, 32'h0, 32'h0);
    cycle();
    force_ff = 1'b0;
    resetn = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    cycle();
    drv(1, 32'h10, 0, 0, 0, 0);
    cycle();
    drv(0, 0, 0, 0, 0, 0);
    repeat (5) cycle();
    chk("fetch_hold", if_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 12; i++) begin
      drv(1, 32'h100 + 32'(i * 4), 1, 0, 32'h200 + 32'(i * 4), 0);
      cycle();
      n_if += int'(m_if_g);
    end
    chk("starve_if_count", 32'(n_if), 32'd3);
    drv(0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    drv(0, 0, 1, 1, 32'h20, 32'h00001234);
    cycle();
    drv(1, 32'h20, 0, 0, 0, 0);
    cycle();
    drv(0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    chk("write_read", if_rdata, 32'h00001234);
    for (int i = 0; i < 3; i++) begin
      drv(1, 32'(i * 4), 0, 0, 0, 0);
      cycle();
    end
    drv(0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    drv(1, 32'h10, 0, 0, 0, 0);
    cycle();
    drv(0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    repeat (2) cycle();
    chk("reset_mid_read", if_rdata, 32'd0);
    for (int i = 0; i < 400; i++) begin
      if (!if_req || m_if_g) begin
        if_req = ($urandom_range(0, 3) != 0);
        if_addr = {22'd0, 8'($urandom), 2'b00};
      end
      if (!dm_req || m_dm_g) begin
        dm_req = ($urandom_range(0, 2) != 0);
        dm_we = $urandom_range(0, 1) == 1;
        dm_addr = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
        dm_wdata = $urandom;
      end
      resetn = ($urandom_range(0, 49) != 0);
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
